// File: rtl/game_referee_pkg.sv
// game_referee_pkg: shared definitions for the game referee slice.
// Holds the state encodings, tile coordinate widths and the level ceiling.
package game_referee_pkg;

   typedef enum logic [1:0] {
      STATE_PLAY     = 2'd0,
      STATE_HIT      = 2'd1,
      STATE_GAMEOVER = 2'd2
   } state_t;

   localparam int TILE_X_W  = 5;
   localparam int TILE_Y_W  = 4;
   localparam int LEVEL_W   = 4;
   localparam int LIVES_W   = 2;
   localparam int LEVEL_MAX = 15;

   // Level counter increment that sticks at LEVEL_MAX.
   function automatic logic [LEVEL_W-1:0] level_sat_inc(input logic [LEVEL_W-1:0] lvl);
      return (lvl == LEVEL_W'(LEVEL_MAX)) ? lvl : lvl + LEVEL_W'(1);
   endfunction

endpackage

// File: rtl/game_referee_obstacle_scanner.sv
// game_referee_obstacle_scanner: walks one obstacle slot per clock and
// raises a one-cycle hit strobe the cycle after a slot overlaps the player.
// The index is held at 0 whenever i_enable is low.
module game_referee_obstacle_scanner
   import game_referee_pkg::*;
#(
   parameter int NUM_OBST = 8
) (
   input  logic                         i_Clk,
   input  logic                         i_reset,
   input  logic                         i_enable,
   input  logic [TILE_X_W-1:0]          i_player_x,
   input  logic [TILE_Y_W-1:0]          i_player_y,
   input  logic [TILE_X_W*NUM_OBST-1:0] i_obst_x,
   input  logic [TILE_Y_W*NUM_OBST-1:0] i_obst_y,
   input  logic [NUM_OBST-1:0]          i_obst_valid,
   output logic                         o_hit_strobe
);

   localparam int IDX_W = (NUM_OBST > 1) ? $clog2(NUM_OBST) : 1;

   logic [IDX_W-1:0]    idx;
   logic [TILE_X_W-1:0] sel_x;
   logic [TILE_Y_W-1:0] sel_y;
   logic                sel_valid;
   logic                match;

   // Slot mux: pick the obstacle addressed by the current scan index.
   always_comb begin
      sel_x     = '0;
      sel_y     = '0;
      sel_valid = 1'b0;
      for (int k = 0; k < NUM_OBST; k++) begin
         if (idx == IDX_W'(k)) begin
            sel_x     = i_obst_x[k*TILE_X_W +: TILE_X_W];
            sel_y     = i_obst_y[k*TILE_Y_W +: TILE_Y_W];
            sel_valid = i_obst_valid[k];
         end
      end
   end

   assign match = sel_valid && (sel_x == i_player_x) && (sel_y == i_player_y);

   // Scan index and registered hit strobe; both cleared while disabled.
   always_ff @(posedge i_Clk) begin
      if (i_reset) begin
         idx          <= '0;
         o_hit_strobe <= 1'b0;
      end else if (i_enable) begin
         idx          <= (idx == IDX_W'(NUM_OBST-1)) ? '0 : idx + IDX_W'(1);
         o_hit_strobe <= match;
      end else begin
         idx          <= '0;
         o_hit_strobe <= 1'b0;
      end
   end

endmodule

// File: rtl/game_referee.sv
// game_referee: game-rule stage behind the player block. Detects
// player/obstacle overlap, tracks level and lives, drives the hit flash and
// the return-to-origin pulse. o_state exposes the FSM state directly.
// Optional feature macro: GAME_REFEREE_LIVES_EN (lives counting and the
// GAMEOVER state). Without it lives are fixed and HIT always returns to PLAY.
module game_referee
   import game_referee_pkg::*;
#(
   parameter int NUM_OBST   = 8,
   parameter int HIT_CYCLES = 25_000_000,
   parameter int FLASH_DIV  = 3_125_000,
   parameter int LIVES_INIT = 3
) (
   input  logic                         i_Clk,
   input  logic                         i_reset,
   input  logic [4:0]                   i_player_x,
   input  logic [3:0]                   i_player_y,
   input  logic [5*NUM_OBST-1:0]        i_obst_x,
   input  logic [4*NUM_OBST-1:0]        i_obst_y,
   input  logic [NUM_OBST-1:0]          i_obst_valid,
   input  logic                         i_start,
   output logic [1:0]                   o_state,
   output logic [1:0]                   o_lives,
   output logic [3:0]                   o_level,
   output logic                         o_level_up,
   output logic                         o_player_reset,
   output logic                         o_flash
);

   localparam int TIMER_W = (HIT_CYCLES > 1) ? $clog2(HIT_CYCLES) : 1;
   localparam int FDIV_W  = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

   state_t               state;
   state_t               state_next;
   logic                 hit_strobe;
   logic                 goal_q;
   logic                 goal_q2;
   logic                 goal_edge;
   logic                 hit_take;
   logic                 hit_done;
   logic                 restart_take;
   logic                 restart_pulse;
   logic [TIMER_W-1:0]   timer;
   logic [FDIV_W-1:0]    fcnt;
   logic [LEVEL_W-1:0]   level;

   game_referee_obstacle_scanner #(
      .NUM_OBST (NUM_OBST)
   ) u_scanner (
      .i_Clk        (i_Clk),
      .i_reset      (i_reset),
      .i_enable     (state == STATE_PLAY),
      .i_player_x   (i_player_x),
      .i_player_y   (i_player_y),
      .i_obst_x     (i_obst_x),
      .i_obst_y     (i_obst_y),
      .i_obst_valid (i_obst_valid),
      .o_hit_strobe (hit_strobe)
   );

   // A goal edge in the same cycle as a hit strobe wins; the hit is dropped.
   assign goal_edge    = goal_q & ~goal_q2;
   assign hit_take     = (state == STATE_PLAY) && hit_strobe && !goal_edge;
   assign hit_done     = (state == STATE_HIT) && (timer == '0);
   assign restart_take = (state == STATE_GAMEOVER) && i_start;

   // FSM state register.
   always_ff @(posedge i_Clk) begin
      if (i_reset) state <= STATE_PLAY;
      else         state <= state_next;
   end

`ifdef GAME_REFEREE_LIVES_EN
   logic [LIVES_W-1:0] lives;

   // Lives: lose one on entering HIT, refill on restart, never below zero.
   always_ff @(posedge i_Clk) begin
      if (i_reset)                          lives <= LIVES_W'(LIVES_INIT);
      else if (hit_take && lives != '0)     lives <= lives - LIVES_W'(1);
      else if (restart_take)                lives <= LIVES_W'(LIVES_INIT);
   end

   assign o_lives = lives;
`else
   assign o_lives = LIVES_W'(LIVES_INIT);
`endif

   // FSM next-state: HIT exits to GAMEOVER only when lives are exhausted.
   always_comb begin
      state_next = state;
      case (state)
         STATE_PLAY: begin
            if (hit_take) state_next = STATE_HIT;
         end
         STATE_HIT: begin
            if (hit_done) begin
`ifdef GAME_REFEREE_LIVES_EN
               state_next = (lives == '0) ? STATE_GAMEOVER : STATE_PLAY;
`else
               state_next = STATE_PLAY;
`endif
            end
         end
         STATE_GAMEOVER: begin
            if (restart_take) state_next = STATE_PLAY;
         end
         default: state_next = STATE_PLAY;
      endcase
   end

   // Goal edge detect and level counter; goals outside PLAY are ignored.
   always_ff @(posedge i_Clk) begin
      if (i_reset) begin
         goal_q        <= 1'b0;
         goal_q2       <= 1'b0;
         level         <= '0;
         o_level_up    <= 1'b0;
         restart_pulse <= 1'b0;
      end else begin
         goal_q        <= (i_player_y == '0);
         goal_q2       <= goal_q;
         o_level_up    <= 1'b0;
         restart_pulse <= 1'b0;
         if ((state == STATE_PLAY) && goal_edge) begin
            o_level_up <= 1'b1;
            level      <= level_sat_inc(level);
         end else if (restart_take) begin
            level         <= '0;
            restart_pulse <= 1'b1;
         end
      end
   end

   // Hit timer and flash divider; flash ends lit only when entering GAMEOVER.
   always_ff @(posedge i_Clk) begin
      if (i_reset) begin
         timer   <= '0;
         fcnt    <= '0;
         o_flash <= 1'b0;
      end else if (hit_take) begin
         timer   <= TIMER_W'(HIT_CYCLES-1);
         fcnt    <= '0;
         o_flash <= 1'b1;
      end else if (state == STATE_HIT) begin
         if (timer == '0) begin
            o_flash <= (state_next == STATE_GAMEOVER);
         end else begin
            timer <= timer - TIMER_W'(1);
            if (fcnt == FDIV_W'(FLASH_DIV-1)) begin
               fcnt    <= '0;
               o_flash <= ~o_flash;
            end else begin
               fcnt <= fcnt + FDIV_W'(1);
            end
         end
      end else if (restart_take) begin
         o_flash <= 1'b0;
      end
   end

   // Player return pulse: last HIT cycle, or the cycle after a restart.
   assign o_player_reset = hit_done | restart_pulse;
   assign o_state        = state;
   assign o_level        = level;

endmodule

// File: tb/tb_game_referee.sv
// tb_game_referee: directed scenarios for game_referee with a small
// expected-value queue for levels and lives.
module tb_game_referee;

  localparam int NUM_OBST   = 4;
  localparam int HIT_CYCLES = 20;
  localparam int FLASH_DIV  = 4;
  localparam int LIVES_INIT = 3;

  logic                  clk;
  logic                  rst;
  logic [4:0]            player_x;
  logic [3:0]            player_y;
  logic [5*NUM_OBST-1:0] obst_x;
  logic [4*NUM_OBST-1:0] obst_y;
  logic [NUM_OBST-1:0]   obst_valid;
  logic                  start;
  logic [1:0]            o_state;
  logic [1:0]            o_lives;
  logic [3:0]            o_level;
  logic                  o_level_up;
  logic                  o_player_reset;
  logic                  o_flash;

  int checks   = 0;
  int failures = 0;
  int level_model;
  int lives_model;

  logic [3:0] level_q[$];
  logic [1:0] lives_q[$];

  game_referee #(
    .NUM_OBST   (NUM_OBST),
    .HIT_CYCLES (HIT_CYCLES),
    .FLASH_DIV  (FLASH_DIV),
    .LIVES_INIT (LIVES_INIT)
  ) dut (
    .i_Clk          (clk),
    .i_reset        (rst),
    .i_player_x     (player_x),
    .i_player_y     (player_y),
    .i_obst_x       (obst_x),
    .i_obst_y       (obst_y),
    .i_obst_valid   (obst_valid),
    .i_start        (start),
    .o_state        (o_state),
    .o_lives        (o_lives),
    .o_level        (o_level),
    .o_level_up     (o_level_up),
    .o_player_reset (o_player_reset),
    .o_flash        (o_flash)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    level_model = 0;
    lives_model = LIVES_INIT;
  endtask

  // driver: one goal visit (y 1 -> 0 for one cycle -> 14)
  task automatic drive_goal();
    int pulses;
    int at;
    logic [3:0] exp_lvl;
    player_y = 4'd1;
    step();
    player_y = 4'd0;
    level_model = (level_model >= 15) ? 15 : level_model + 1;
    level_q.push_back(level_model[3:0]);
    pulses = 0;
    at = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) player_y = 4'd14;
      checks++;
      if (o_state !== 2'd0) begin
        failures++;
        $display("FAIL goal_state: cycle %0d state=%0d required=0", c, o_state);
      end
      if (o_level_up === 1'b1) begin
        pulses++;
        at = c;
        if (level_q.size() > 0) begin
          exp_lvl = level_q.pop_front();
          checks++;
          if (o_level !== exp_lvl) begin
            failures++;
            $display("FAIL goal_level: level=%0d required=%0d", o_level, exp_lvl);
          end
        end
      end
    end
    checks++;
    if (pulses != 1 || at != 2) begin
      failures++;
      $display("FAIL goal_pulse: pulses=%0d at_cycle=%0d required 1 pulse at cycle 2", pulses, at);
    end
  endtask

  // driver: overlap at slot 2, then walk the whole HIT window.
  // abort_at >= 0 asserts reset at that HIT cycle and checks reset values.
  task automatic drive_hit(input int abort_at);
    int n;
    logic seen;
    logic exp_flash;
    logic exp_pr;
    logic [1:0] exp_lives;
    logic [1:0] exp_after;
    obst_x = '0;
    obst_y = '0;
    obst_x[2*5 +: 5] = 5'd11;
    obst_y[2*4 +: 4] = 4'd14;
    obst_valid = 4'b0100;
    player_x = 5'd11;
    player_y = 4'd14;
`ifdef GAME_REFEREE_LIVES_EN
    if (lives_model > 0) lives_model--;
`endif
    lives_q.push_back(lives_model[1:0]);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 8) begin
      step();
      n++;
      if (o_state === 2'd1) seen = 1'b1;
    end
    obst_valid = '0;
    player_x = 5'd1;
    exp_lives = lives_q.pop_front();
    checks++;
    if (!seen || n > NUM_OBST + 1) begin
      failures++;
      $display("FAIL hit_latency: cycles=%0d seen=%0b required<=%0d", n, seen, NUM_OBST + 1);
    end
    if (!seen) return;
    checks++;
    if (o_lives !== exp_lives) begin
      failures++;
      $display("FAIL hit_lives: lives=%0d required=%0d", o_lives, exp_lives);
    end
    for (int i = 0; i < HIT_CYCLES; i++) begin
      if (i > 0) step();
      exp_flash = (((i / FLASH_DIV) % 2) == 0);
      exp_pr    = (i == HIT_CYCLES - 1);
      checks++;
      if (o_state !== 2'd1) begin
        failures++;
        $display("FAIL hit_state: hit cycle %0d state=%0d required=1", i, o_state);
      end
      checks++;
      if (o_flash !== exp_flash) begin
        failures++;
        $display("FAIL hit_flash: hit cycle %0d flash=%0b required=%0b", i, o_flash, exp_flash);
      end
      checks++;
      if (o_player_reset !== exp_pr) begin
        failures++;
        $display("FAIL hit_player_reset: hit cycle %0d pr=%0b required=%0b", i, o_player_reset, exp_pr);
      end
      if (i == abort_at) begin
        rst = 1'b1;
        step();
        checks++;
        if (o_state !== 2'd0 || o_lives !== 2'(LIVES_INIT) || o_level !== 4'd0 ||
            o_flash !== 1'b0 || o_player_reset !== 1'b0 || o_level_up !== 1'b0) begin
          failures++;
          $display("FAIL reset_mid_hit: state=%0d lives=%0d level=%0d flash=%0b pr=%0b lu=%0b required 0/%0d/0/0/0/0",
                   o_state, o_lives, o_level, o_flash, o_player_reset, o_level_up, LIVES_INIT);
        end
        rst = 1'b0;
        level_model = 0;
        lives_model = LIVES_INIT;
        return;
      end
    end
    step();
    exp_after = (lives_model == 0) ? 2'd2 : 2'd0;
    checks++;
    if (o_state !== exp_after) begin
      failures++;
      $display("FAIL hit_exit_state: state=%0d required=%0d", o_state, exp_after);
    end
    checks++;
    if (o_player_reset !== 1'b0 || o_flash !== (lives_model == 0)) begin
      failures++;
      $display("FAIL hit_exit_outputs: pr=%0b flash=%0b required pr=0 flash=%0b",
               o_player_reset, o_flash, (lives_model == 0));
    end
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    step();
    checks++;
    if (o_state !== 2'd0) begin failures++; $display("FAIL reset_state: %0d required 0", o_state); end
    checks++;
    if (o_lives !== 2'(LIVES_INIT)) begin failures++; $display("FAIL reset_lives: %0d required %0d", o_lives, LIVES_INIT); end
    checks++;
    if (o_level !== 4'd0) begin failures++; $display("FAIL reset_level: %0d required 0", o_level); end
    checks++;
    if (o_level_up !== 1'b0 || o_player_reset !== 1'b0 || o_flash !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses: lu=%0b pr=%0b flash=%0b required 0", o_level_up, o_player_reset, o_flash);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_goal();
    drive_goal();
  endtask

  task automatic test_goal_vs_hit();
    obst_x = {NUM_OBST{5'd5}};
    obst_y = '0;
    obst_valid = '1;
    player_x = 5'd5;
    drive_goal();
    obst_valid = '0;
    player_x = 5'd1;
    checks++;
    if (o_lives !== lives_model[1:0]) begin
      failures++;
      $display("FAIL goal_vs_hit_lives: lives=%0d required=%0d", o_lives, lives_model);
    end
  endtask

  task automatic test_goal_sat();
    for (int g = 0; g < 16; g++) drive_goal();
    checks++;
    if (o_level !== 4'd15) begin
      failures++;
      $display("FAIL goal_saturate: level=%0d required=15", o_level);
    end
  endtask

  task automatic test_hit();
    drive_hit(-1);
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (o_state !== 2'd0 || o_player_reset !== 1'b0 || o_level !== level_model[3:0]) begin
      failures++;
      $display("FAIL start_in_play: state=%0d pr=%0b level=%0d required 0/0/%0d",
               o_state, o_player_reset, o_level, level_model);
    end
  endtask

`ifdef GAME_REFEREE_LIVES_EN
  task automatic test_gameover();
    apply_reset();
    drive_goal();
    for (int h = 0; h < LIVES_INIT; h++) drive_hit(-1);
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (o_state !== 2'd2 || o_lives !== 2'd0 || o_flash !== 1'b1) begin
        failures++;
        $display("FAIL gameover_hold: state=%0d lives=%0d flash=%0b required 2/0/1", o_state, o_lives, o_flash);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    level_model = 0;
    lives_model = LIVES_INIT;
    checks++;
    if (o_state !== 2'd0 || o_lives !== 2'(LIVES_INIT) || o_level !== 4'd0 || o_player_reset !== 1'b1) begin
      failures++;
      $display("FAIL restart: state=%0d lives=%0d level=%0d pr=%0b required 0/%0d/0/1",
               o_state, o_lives, o_level, o_player_reset, LIVES_INIT);
    end
    step();
    checks++;
    if (o_player_reset !== 1'b0) begin
      failures++;
      $display("FAIL restart_pulse_width: pr=%0b required 0", o_player_reset);
    end
  endtask
`else
  task automatic test_no_gameover();
    apply_reset();
    for (int h = 0; h < 4; h++) drive_hit(-1);
    checks++;
    if (o_state !== 2'd0 || o_lives !== 2'(LIVES_INIT)) begin
      failures++;
      $display("FAIL no_gameover: state=%0d lives=%0d required 0/%0d", o_state, o_lives, LIVES_INIT);
    end
  endtask
`endif

  task automatic test_reset_mid_hit();
    int bad;
    drive_hit(10);
    bad = 0;
    for (int c = 0; c < HIT_CYCLES + 5; c++) begin
      step();
      if (o_player_reset !== 1'b0 || o_state !== 2'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_mid_hit_after: %0d bad cycles required 0", bad);
    end
  endtask

  // main sequence and final report
  initial begin
    rst        = 1'b1;
    player_x   = 5'd1;
    player_y   = 4'd14;
    obst_x     = '0;
    obst_y     = '0;
    obst_valid = '0;
    start      = 1'b0;
    level_model = 0;
    lives_model = LIVES_INIT;

    test_reset();
    test_goal();
    test_goal_vs_hit();
    test_goal_sat();
    test_hit();
    test_start_ignored();
`ifdef GAME_REFEREE_LIVES_EN
    test_gameover();
`else
    test_no_gameover();
`endif
    test_reset_mid_hit();

    checks++;
    if (level_q.size() != 0 || lives_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: level_q=%0d lives_q=%0d required 0/0", level_q.size(), lives_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
